// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: datapath widths, the ALU
// operation code set, the controller state encoding and small code
// classification helpers used by the FSM.
package alu_seq_ctrl_pkg;

    localparam int LEN_DATA     = 64;
    localparam int LEN_TYPE_ALU = 4;

    typedef logic [LEN_TYPE_ALU-1:0] alu_code_t;

    // ALU operation codes. 1..11 are single-pass ops executed by the ALU
    // itself; 12/13 are sequenced here as two chained ADD64 passes.
    localparam alu_code_t ALU_ADD64  = 4'd1;
    localparam alu_code_t ALU_SUB64  = 4'd2;
    localparam alu_code_t ALU_AND    = 4'd3;
    localparam alu_code_t ALU_OR     = 4'd4;
    localparam alu_code_t ALU_XOR    = 4'd5;
    localparam alu_code_t ALU_NOT    = 4'd6;
    localparam alu_code_t ALU_SHL    = 4'd7;
    localparam alu_code_t ALU_SHR    = 4'd8;
    localparam alu_code_t ALU_SRA    = 4'd9;
    localparam alu_code_t ALU_CMPEQ  = 4'd10;
    localparam alu_code_t ALU_CMPLT  = 4'd11;
    localparam alu_code_t ALU_ADD128 = 4'd12;
    localparam alu_code_t ALU_SUB128 = 4'd13;

    // Highest legal code; 0 and anything above this are rejected.
    localparam alu_code_t ALU_CODE_MAX = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_WAIT_LO  = 3'd2,
        ST_ISSUE_HI = 3'd3,
        ST_WAIT_HI  = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    function automatic logic code_is_legal(input alu_code_t code);
        return (code != '0) && (code <= ALU_CODE_MAX);
    endfunction

    function automatic logic code_is_wide(input alu_code_t code);
        return (code == ALU_ADD128) || (code == ALU_SUB128);
    endfunction

endpackage

// File: rtl/alu_seq_tmo.sv
// Watchdog counter for the ALU sequencer.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr_i     - synchronous clear to zero (has priority over en_i)
//   en_i      - count one cycle of waiting
//   tc_o      - terminal count: counter holds TIMEOUT-1
module alu_seq_tmo #(
    parameter int TIMEOUT = 64,
    parameter int LEN_TMO = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [LEN_TMO-1:0] count_q, count_d;

    assign tc_o = (count_q == LEN_TMO'(TIMEOUT - 1));

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            // Saturate at terminal count; the FSM leaves the wait state then.
            count_d = count_q + LEN_TMO'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer between the issue stage and the 64-bit ALU. Accepts one op per
// req handshake, issues one or two ALU passes (ADD128/SUB128 are two chained
// ADD64 passes with carry forwarding), guards each wait with a watchdog and
// returns a buffered 128-bit result on the rsp handshake.
// Ports:
//   clk, rst                     - clock, asynchronous active-low reset
//   req_valid/ready/code/a/b/cin - request handshake and operands
//   alu_en/code/a/b/cin          - ALU issue interface (alu_en is a 1-cycle strobe)
//   alu_result/cout/rdy          - ALU completion (alu_rdy is a 1-cycle pulse)
//   rsp_valid/ready/data/cout/err- response handshake and result
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int LEN_TMO = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [LEN_TYPE_ALU-1:0]   req_code,
    input  logic [2*LEN_DATA-1:0]     req_a,
    input  logic [2*LEN_DATA-1:0]     req_b,
    input  logic                      req_cin,
    output logic                      alu_en,
    output logic [LEN_TYPE_ALU-1:0]   alu_code,
    output logic [LEN_DATA-1:0]       alu_a,
    output logic [LEN_DATA-1:0]       alu_b,
    output logic                      alu_cin,
    input  logic [LEN_DATA-1:0]       alu_result,
    input  logic                      alu_cout,
    input  logic                      alu_rdy,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2*LEN_DATA-1:0]     rsp_data,
    output logic                      rsp_cout,
    output logic                      rsp_err
);

    state_e                state_q, state_d;
    alu_code_t             code_q, code_d;
    logic [LEN_DATA-1:0]   a_hi_q, a_hi_d, b_hi_q, b_hi_d;
    logic                  alu_en_q, alu_en_d;
    alu_code_t             alu_code_q, alu_code_d;
    logic [LEN_DATA-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic                  alu_cin_q, alu_cin_d;
    logic [LEN_DATA-1:0]   rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
    logic                  rsp_cout_q, rsp_cout_d, rsp_err_q, rsp_err_d;
    logic                  waiting, tmo_tc;

    assign waiting = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);

    // Counter runs only while waiting, so it is cleared by every ISSUE state.
    alu_seq_tmo #(
        .TIMEOUT (TIMEOUT),
        .LEN_TMO (LEN_TMO)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!waiting),
        .en_i  (waiting),
        .tc_o  (tmo_tc)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_en    = alu_en_q;
    assign alu_code  = alu_code_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign rsp_data  = {rsp_hi_q, rsp_lo_q};
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        alu_en_d   = 1'b0;
        alu_code_d = alu_code_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_cout_d = rsp_cout_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    code_d     = req_code;
                    a_hi_d     = req_a[2*LEN_DATA-1:LEN_DATA];
                    b_hi_d     = req_b[2*LEN_DATA-1:LEN_DATA];
                    rsp_lo_d   = '0;
                    rsp_hi_d   = '0;
                    rsp_cout_d = 1'b0;
                    rsp_err_d  = 1'b0;
                    if (code_is_legal(req_code)) begin
                        // Low-half operands are registered straight onto the
                        // ALU bus; they double as the latched low operands.
                        state_d  = ST_ISSUE_LO;
                        alu_en_d = 1'b1;
                        alu_a_d  = req_a[LEN_DATA-1:0];
                        if (req_code == ALU_SUB128) begin
                            // a - b == a + ~b + 1, done on the ADD64 path.
                            alu_code_d = ALU_ADD64;
                            alu_b_d    = ~req_b[LEN_DATA-1:0];
                            alu_cin_d  = 1'b1;
                        end else begin
                            alu_code_d = (req_code == ALU_ADD128) ? ALU_ADD64 : req_code;
                            alu_b_d    = req_b[LEN_DATA-1:0];
                            alu_cin_d  = req_cin;
                        end
                    end else begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE_LO: state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                // A completion in the terminal-count cycle still wins.
                if (alu_rdy) begin
                    rsp_lo_d   = alu_result;
                    rsp_cout_d = alu_cout;
                    if (code_is_wide(code_q)) begin
                        state_d    = ST_ISSUE_HI;
                        alu_en_d   = 1'b1;
                        alu_code_d = ALU_ADD64;
                        alu_a_d    = a_hi_q;
                        alu_b_d    = (code_q == ALU_SUB128) ? ~b_hi_q : b_hi_q;
                        alu_cin_d  = alu_cout;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (tmo_tc) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                end
            end
            ST_ISSUE_HI: state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (alu_rdy) begin
                    rsp_hi_d   = alu_result;
                    rsp_cout_d = alu_cout;
                    state_d    = ST_RESP;
                end else if (tmo_tc) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            alu_en_q   <= 1'b0;
            alu_code_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            rsp_lo_q   <= '0;
            rsp_hi_q   <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            alu_en_q   <= alu_en_d;
            alu_code_q <= alu_code_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            rsp_lo_q   <= rsp_lo_d;
            rsp_hi_q   <= rsp_hi_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a behavioural ALU of programmable
// latency. Expected values are hand-computed constants.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_cin;
    logic [3:0]   req_code;
    logic [127:0] req_a, req_b;
    logic         alu_en, alu_cin, alu_cout, alu_rdy;
    logic [3:0]   alu_code;
    logic [63:0]  alu_a, alu_b, alu_result;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_err;
    logic [127:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl #(.TIMEOUT(64), .LEN_TMO(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_code   (req_code),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .alu_en     (alu_en),
        .alu_code   (alu_code),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_rdy    (alu_rdy),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    int          mdl_lat  = 3;
    logic        mdl_mute = 1'b0;   // never answer (watchdog test)
    int          n_pulse  = 0;
    logic [3:0]  p_code [0:255];
    logic [63:0] p_a    [0:255];
    logic [63:0] p_b    [0:255];
    logic        p_cin  [0:255];
    logic        busy   = 1'b0;
    int          cnt    = 0;
    logic [64:0] m_res;

    always @(negedge clk) begin
        alu_rdy = 1'b0;
        if (busy) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                alu_rdy = 1'b1;
                {alu_cout, alu_result} = m_res;
                busy = 1'b0;
            end
        end
        if (alu_en === 1'b1) begin
            p_code[n_pulse[7:0]] = alu_code;
            p_a[n_pulse[7:0]]    = alu_a;
            p_b[n_pulse[7:0]]    = alu_b;
            p_cin[n_pulse[7:0]]  = alu_cin;
            n_pulse = n_pulse + 1;
            if (!mdl_mute) begin
                busy = 1'b1;
                cnt  = mdl_lat;
                case (alu_code)
                    ALU_ADD64: m_res = {1'b0, alu_a} + {1'b0, alu_b} + 65'(alu_cin);
                    ALU_XOR:   m_res = {1'b0, alu_a ^ alu_b};
                    default:   m_res = '0;
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present one request in IDLE, then wait (bounded) for rsp_valid.
    // cyc counts sample points after the acceptance edge.
    task automatic run_op(input logic [3:0] code, input logic [127:0] a,
                          input logic [127:0] b, input logic cin, output int cyc);
        req_code  = code;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_valid = 1'b1;
        check("req_ready_idle", 128'(req_ready), 128'(1));
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_rsp(input string tag, input int cyc, input int exp_cyc,
                             input logic [127:0] data, input logic cout,
                             input logic err, input int pulses, input int base);
        check({tag, "_lat"},    128'(cyc), 128'(exp_cyc));
        check({tag, "_valid"},  128'(rsp_valid), 128'(1));
        check({tag, "_data"},   rsp_data, data);
        check({tag, "_cout"},   128'(rsp_cout), 128'(cout));
        check({tag, "_err"},    128'(rsp_err), 128'(err));
        check({tag, "_pulses"}, 128'(n_pulse - base), 128'(pulses));
    endtask

    task automatic rsp_accept(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 128'(rsp_valid), 128'(0));
        check({tag, "_ready_back"}, 128'(req_ready), 128'(1));
    endtask

    // ---------------- stimulus ----------------
    int base;
    int cyc;
    logic [3:0] bad_codes [0:2];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_code = '0; req_a = '0; req_b = '0;
        req_cin = 1'b0; rsp_ready = 1'b0;
        bad_codes[0] = 4'd0; bad_codes[1] = 4'd14; bad_codes[2] = 4'd15;
        #2;
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_alu_en",    128'(alu_en), 128'(0));
        check("rst_alu_a",     128'(alu_a), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_data",  rsp_data, 128'(0));
        check("rst_rsp_err",   128'(rsp_err), 128'(0));
        tick(); tick();
        rst = 1'b1;
        tick();

        // ADD64 with carry out, latency 3: ISSUE + 3 WAIT -> RESP at sample 5
        base = n_pulse;
        run_op(ALU_ADD64, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, cyc);
        check_rsp("add64", cyc, 5, 128'h0, 1'b1, 1'b0, 1, base);
        check("add64_code", 128'(p_code[base[7:0]]), 128'(ALU_ADD64));
        check("add64_b",    128'(p_b[base[7:0]]), 128'h1);
        check("add64_cin",  128'(p_cin[base[7:0]]), 128'(0));
        rsp_accept("add64");

        // Single-pass XOR: code and cin pass through unchanged
        base = n_pulse;
        run_op(ALU_XOR, 128'hF0, 128'hFF, 1'b1, cyc);
        check_rsp("xor", cyc, 5, 128'h0F, 1'b0, 1'b0, 1, base);
        check("xor_code", 128'(p_code[base[7:0]]), 128'(ALU_XOR));
        check("xor_cin",  128'(p_cin[base[7:0]]), 128'(1));
        rsp_accept("xor");

        // ADD128: carry propagates into the high pass
        base = n_pulse;
        run_op(ALU_ADD128, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, cyc);
        check_rsp("add128", cyc, 9, 128'h0000_0000_0000_0002_0000_0000_0000_0000, 1'b0, 1'b0, 2, base);
        check("add128_code_lo", 128'(p_code[base[7:0]]), 128'(ALU_ADD64));
        check("add128_code_hi", 128'(p_code[8'(base + 1)]), 128'(ALU_ADD64));
        check("add128_a_hi",    128'(p_a[8'(base + 1)]), 128'h1);
        check("add128_cin_hi",  128'(p_cin[8'(base + 1)]), 128'(1));
        rsp_accept("add128");

        // SUB128: 2^64 - 1, done as two ADD64 passes with inverted B
        base = n_pulse;
        run_op(ALU_SUB128, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'h1, 1'b0, cyc);
        check_rsp("sub128", cyc, 9, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 2, base);
        check("sub128_code_lo", 128'(p_code[base[7:0]]), 128'(ALU_ADD64));
        check("sub128_b_lo",    128'(p_b[base[7:0]]), 128'hFFFF_FFFF_FFFF_FFFE);
        check("sub128_cin_lo",  128'(p_cin[base[7:0]]), 128'(1));
        check("sub128_b_hi",    128'(p_b[8'(base + 1)]), 128'hFFFF_FFFF_FFFF_FFFF);
        check("sub128_cin_hi",  128'(p_cin[8'(base + 1)]), 128'(0));
        rsp_accept("sub128");

        // Illegal codes: no ALU issue, error response
        for (int i = 0; i < 3; i++) begin
            base = n_pulse;
            req_code = bad_codes[i]; req_a = '1; req_b = '1; req_cin = 1'b1;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            tick();
            check($sformatf("bad%0d_valid", bad_codes[i]), 128'(rsp_valid), 128'(1));
            check($sformatf("bad%0d_err", bad_codes[i]),   128'(rsp_err), 128'(1));
            check($sformatf("bad%0d_data", bad_codes[i]),  rsp_data, 128'(0));
            check($sformatf("bad%0d_pulses", bad_codes[i]), 128'(n_pulse - base), 128'(0));
            rsp_accept("bad");
        end

        // Watchdog: ALU never answers -> error after 64 wait cycles
        mdl_mute = 1'b1;
        base = n_pulse;
        run_op(ALU_AND, 128'h3, 128'h5, 1'b0, cyc);
        check_rsp("tmo", cyc, 66, 128'h0, 1'b0, 1'b1, 1, base);
        mdl_mute = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tmo_hold_valid", 128'(rsp_valid), 128'(1));
            check("tmo_hold_err",   128'(rsp_err), 128'(1));
            check("tmo_hold_data",  rsp_data, 128'(0));
            check("tmo_hold_ready", 128'(req_ready), 128'(0));
        end
        rsp_accept("tmo");

        // rdy in the terminal-count cycle wins over the timeout
        mdl_lat = 64;
        base = n_pulse;
        run_op(ALU_ADD64, 128'h5, 128'h7, 1'b1, cyc);
        check_rsp("tmo_edge", cyc, 66, 128'hD, 1'b0, 1'b0, 1, base);
        rsp_accept("tmo_edge");
        mdl_lat = 3;

        // Reset during WAIT_HI, late rdy afterwards must be ignored
        base = n_pulse;
        req_code = ALU_ADD128; req_a = 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF;
        req_b = 128'h1; req_cin = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && n_pulse < base + 2; i++) tick();
        check("rst_mid_reach_hi", 128'(n_pulse - base), 128'(2));
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_alu_en",    128'(alu_en), 128'(0));
        check("rst_mid_alu_code",  128'(alu_code), 128'(0));
        check("rst_mid_alu_b",     128'(alu_b), 128'(0));
        check("rst_mid_alu_cin",   128'(alu_cin), 128'(0));
        check("rst_mid_req_ready", 128'(req_ready), 128'(1));
        check("rst_mid_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_mid_rsp_data",  rsp_data, 128'(0));
        tick();
        rst = 1'b1;
        tick();            // late alu_rdy is driven here
        tick();
        check("late_rdy_valid", 128'(rsp_valid), 128'(0));
        check("late_rdy_ready", 128'(req_ready), 128'(1));
        check("late_rdy_alu_en", 128'(alu_en), 128'(0));
        check("late_rdy_data",  rsp_data, 128'(0));

        base = n_pulse;
        run_op(ALU_ADD64, 128'h1234, 128'h1111, 1'b1, cyc);
        check_rsp("after_rst", cyc, 5, 128'h2346, 1'b0, 1'b0, 1, base);
        rsp_accept("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer between the issue stage and the ALU/adder64 datapath.
- Accepts one operation per valid/ready handshake, drives the ALU issue interface and waits for the ALU's rdy pulse.
- Implements the two-step ADD128/SUB128 codes as two chained 64-bit ADD64 passes, with carry forwarding and a watchdog timeout.
- Returns a buffered 128-bit result on a valid/ready response port.

Parameters:
- LEN_DATA, 64, datapath width of one ALU pass.
- LEN_TYPE_ALU, 4, width of the ALU operation code.
- TIMEOUT, 64, maximum cycles to wait for alu_rdy after an issue before error.
- LEN_TMO, 7, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_code  in  LEN_TYPE_ALU  operation code (ALU code set 1..13).
- req_a  in  2*LEN_DATA  operand A; [63:0] is the low half, [127:64] the high half.
- req_b  in  2*LEN_DATA  operand B, same layout as req_a.
- req_cin  in  1  carry-in for ADD64/ADD128.
- alu_en  out  1  one-cycle issue strobe to the ALU.
- alu_code  out  LEN_TYPE_ALU  code presented to the ALU.
- alu_a  out  LEN_DATA  ALU operand A.
- alu_b  out  LEN_DATA  ALU operand B.
- alu_cin  out  1  ALU carry-in.
- alu_result  in  LEN_DATA  ALU result, valid when alu_rdy is high.
- alu_cout  in  1  ALU carry-out, valid when alu_rdy is high.
- alu_rdy  in  1  one-cycle ALU completion pulse.
- rsp_valid  out  1  response held valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  2*LEN_DATA  result; high half is 0 for single-pass ops.
- rsp_cout  out  1  final carry-out.
- rsp_err  out  1  illegal code or timeout.

Behaviour:
- Reset (rst=0, asynchronous) forces the following; a reset mid-operation abandons it, and a late alu_rdy after reset is ignored.
  - state=IDLE
  - req_ready=1
  - alu_en=0, alu_code=0, alu_a=0, alu_b=0, alu_cin=0
  - rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0
  - timeout counter=0
- States: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
- IDLE:
  - req_ready=1. A request is accepted when req_valid & req_ready.
  - Accepting latches code, both operands and req_cin, and drops req_ready the next cycle.
  - Legal code (1..13) -> ISSUE_LO.
  - Code 0, 14 or 15 -> RESP with rsp_err=1 and rsp_data=0; the ALU is not issued.
- ISSUE_LO: alu_en=1 for exactly one cycle, then -> WAIT_LO. Operands presented:
  - Single-pass codes 1..11: alu_code=latched code, alu_a=a[63:0], alu_b=b[63:0], alu_cin=latched cin.
  - ADD128: alu_code=ADD64, alu_a=a[63:0], alu_b=b[63:0], alu_cin=latched cin.
  - SUB128: alu_code=ADD64, alu_a=a[63:0], alu_b=~b[63:0], alu_cin=1.
  - The ALU's own SUB path is never used for the 128-bit codes.
- WAIT_LO:
  - alu_en=0, alu_* held stable. The timeout counter increments each cycle.
  - On alu_rdy, latch alu_result into the low half and save alu_cout.
    - Codes 12/13 -> ISSUE_HI.
    - Other codes -> RESP with high half=0 and rsp_cout=alu_cout.
  - If the counter reaches TIMEOUT-1 without alu_rdy -> RESP with rsp_err=1.
  - alu_rdy in the same cycle as the timeout wins (no error).
- ISSUE_HI: one-cycle alu_en with alu_code=ADD64, alu_a=a[127:64], alu_cin=saved cout.
  - alu_b=b[127:64] for ADD128; alu_b=~b[127:64] for SUB128.
  - The counter clears, then -> WAIT_HI.
- WAIT_HI: same rules as WAIT_LO. alu_rdy latches the high half and rsp_cout -> RESP.
- RESP:
  - rsp_valid=1 with data, cout and err held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid=0 and req_ready=1 from the next cycle, -> IDLE.
  - There is no req/rsp bypass; throughput is one op per (2 + ALU latency + 1) cycles per pass.
- An alu_rdy outside the WAIT states is ignored.
- Codes 12/13 carry the full 128-bit semantics defined above. SUB128 rsp_cout=1 means no borrow.

Decomposition:
- Shared package/define file holds:
  - the ALU_* code constants (1..13)
  - LEN_DATA and LEN_TYPE_ALU
  - the state encoding localparams
  - the ALU_CODE_MAX=13 legality bound
- One natural sub-module: alu_seq_tmo, a loadable/clearable watchdog counter with a terminal-count flag.
- The FSM and operand muxing stay in alu_seq_ctrl.

Test Plan:
- ADD64, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, ALU model latency 3 -> exactly one alu_en pulse; rsp_data[63:0]=0, high half 0, rsp_cout=1, rsp_err=0.
- ADD128, a=0x0000..0001_FFFF_FFFF_FFFF_FFFF, b=1 -> two alu_en pulses; second has alu_cin=1; rsp_data=0x0000_0000_0000_0002_0000_0000_0000_0000, rsp_cout=0.
- SUB128, a=0x1_0000_0000_0000_0000, b=1 -> first pass alu_b=0xFFFF_FFFF_FFFF_FFFE, alu_cin=1; rsp_data=0x0000..0000_FFFF_FFFF_FFFF_FFFF, rsp_cout=1.
- req_code=14 -> no alu_en; rsp_valid with rsp_err=1 and rsp_data=0 two cycles after acceptance.
- ALU model never asserts rdy, TIMEOUT=64 -> rsp_err=1 after 64 wait cycles. Then hold rsp_ready=0 for 5 cycles: response stays stable and req_ready=0 throughout.
- Deassert rst during WAIT_HI, then pulse alu_rdy -> outputs at reset values, no rsp_valid; the next request completes correctly.
